// File: rtl/sync_dual_port_ram_if.sv
// Bus bundle for the dual-port RAM: two access ports plus status flags.
// The RAM takes the slave side; the requester takes the master side.
interface sync_dual_port_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    localparam int NB = DATA_W / 8;

    logic              en_a;
    logic              we_a;
    logic [NB-1:0]     be_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] din_a;
    logic [DATA_W-1:0] dout_a;
    logic              valid_a;

    logic              en_b;
    logic              we_b;
    logic [NB-1:0]     be_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] din_b;
    logic [DATA_W-1:0] dout_b;
    logic              valid_b;

    logic              init_busy;
    logic              collision;

    modport master (
        output en_a, we_a, be_a, addr_a, din_a,
        output en_b, we_b, be_b, addr_b, din_b,
        input  dout_a, valid_a, dout_b, valid_b,
        input  init_busy, collision
    );

    modport slave (
        input  en_a, we_a, be_a, addr_a, din_a,
        input  en_b, we_b, be_b, addr_b, din_b,
        output dout_a, valid_a, dout_b, valid_b,
        output init_busy, collision
    );
endinterface

// File: rtl/sync_dual_port_ram.sv
// True dual-port RAM with byte-masked writes, selectable read-during-write,
// optional output register, post-reset clear sequencer and collision flag.
module sync_dual_port_ram #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 3,
    parameter int                RD_MODE  = 0,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    sync_dual_port_ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_we;
    logic              acc_a, acc_b;
    logic              wr_a, wr_b;
    logic              same_addr;
    logic [DATA_W-1:0] mask_a, mask_b;
    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] new_a, new_b;
    logic [DATA_W-1:0] rd_a, rd_b;

    logic              v1_a_q, v1_a_d, v1_b_q, v1_b_d;
    logic              v2_a_q, v2_a_d, v2_b_q, v2_b_d;
    logic [DATA_W-1:0] d1_a_q, d1_a_d, d1_b_q, d1_b_d;
    logic [DATA_W-1:0] d2_a_q, d2_a_d, d2_b_q, d2_b_d;
    logic              col_q, col_d;

    function automatic logic [DATA_W-1:0] expand(
        input logic [NB-1:0] be
    );
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // Clear sequencer; rst gates the write so memory is untouched in reset
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = ~rst;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (&cnt_q) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_a     = bus.en_a & (state_q == IDLE);
        acc_b     = bus.en_b & (state_q == IDLE);
        wr_a      = acc_a & bus.we_a;
        wr_b      = acc_b & bus.we_b;
        same_addr = bus.addr_a == bus.addr_b;
        mask_a    = expand(bus.be_a);
        mask_b    = expand(bus.be_b);
        old_a     = mem_q[bus.addr_a];
        old_b     = mem_q[bus.addr_b];
        new_b     = (old_b & ~mask_b) | (bus.din_b & mask_b);
        // A merges on top of B's result so overlapping bytes go to A
        new_a     = ((wr_b && same_addr) ? new_b : old_a) & ~mask_a;
        new_a     = new_a | (bus.din_a & mask_a);
        rd_a      = old_a;
        rd_b      = old_b;
        if (RD_MODE == 1 && wr_a) begin
            rd_a = (old_a & ~mask_a) | (bus.din_a & mask_a);
        end
        if (RD_MODE == 1 && wr_b) begin
            rd_b = new_b;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= INIT_VAL;
        end else begin
            if (wr_b) begin
                mem_q[bus.addr_b] <= new_b;
            end
            if (wr_a) begin
                mem_q[bus.addr_a] <= new_a;
            end
        end
    end

    always_comb begin
        v1_a_d = acc_a;
        v1_b_d = acc_b;
        d1_a_d = acc_a ? rd_a : d1_a_q;
        d1_b_d = acc_b ? rd_b : d1_b_q;
        v2_a_d = v1_a_q;
        v2_b_d = v1_b_q;
        d2_a_d = v1_a_q ? d1_a_q : d2_a_q;
        d2_b_d = v1_b_q ? d1_b_q : d2_b_q;
        col_d  = acc_a & acc_b & same_addr
               & ((wr_a & |bus.be_a) | (wr_b & |bus.be_b));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            v1_a_q  <= 1'b0;
            v1_b_q  <= 1'b0;
            v2_a_q  <= 1'b0;
            v2_b_q  <= 1'b0;
            d1_a_q  <= '0;
            d1_b_q  <= '0;
            d2_a_q  <= '0;
            d2_b_q  <= '0;
            col_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v1_a_q  <= v1_a_d;
            v1_b_q  <= v1_b_d;
            v2_a_q  <= v2_a_d;
            v2_b_q  <= v2_b_d;
            d1_a_q  <= d1_a_d;
            d1_b_q  <= d1_b_d;
            d2_a_q  <= d2_a_d;
            d2_b_q  <= d2_b_d;
            col_q   <= col_d;
        end
    end

    assign bus.dout_a    = (OUT_REG != 0) ? d2_a_q : d1_a_q;
    assign bus.dout_b    = (OUT_REG != 0) ? d2_b_q : d1_b_q;
    assign bus.valid_a   = (OUT_REG != 0) ? v2_a_q : v1_a_q;
    assign bus.valid_b   = (OUT_REG != 0) ? v2_b_q : v1_b_q;
    assign bus.collision = col_q;
    assign bus.init_busy = (state_q == CLEAR);
endmodule

// File: tb/tb_sync_dual_port_ram.sv
// Bench for sync_dual_port_ram: dut0 read-first/latency 1,
// dut1 write-first/latency 2, both against a word-level model.
module tb_sync_dual_port_ram;
    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, we_a, en_b, we_b;
    logic [1:0]  be_a, be_b;
    logic [2:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;

    always #5 clk = ~clk;

    sync_dual_port_ram_if #(.DATA_W(16), .ADDR_W(3)) p0 ();
    sync_dual_port_ram_if #(.DATA_W(16), .ADDR_W(3)) p1 ();

    assign p0.en_a = en_a;     assign p1.en_a = en_a;
    assign p0.we_a = we_a;     assign p1.we_a = we_a;
    assign p0.be_a = be_a;     assign p1.be_a = be_a;
    assign p0.addr_a = addr_a; assign p1.addr_a = addr_a;
    assign p0.din_a = din_a;   assign p1.din_a = din_a;
    assign p0.en_b = en_b;     assign p1.en_b = en_b;
    assign p0.we_b = we_b;     assign p1.we_b = we_b;
    assign p0.be_b = be_b;     assign p1.be_b = be_b;
    assign p0.addr_b = addr_b; assign p1.addr_b = addr_b;
    assign p0.din_b = din_b;   assign p1.din_b = din_b;

    sync_dual_port_ram #(
        .DATA_W(16), .ADDR_W(3), .RD_MODE(0), .OUT_REG(0), .INIT_VAL(16'h0)
    ) dut0 (.clk(clk), .rst(rst), .bus(p0));

    sync_dual_port_ram #(
        .DATA_W(16), .ADDR_W(3), .RD_MODE(1), .OUT_REG(1), .INIT_VAL(16'h0)
    ) dut1 (.clk(clk), .rst(rst), .bus(p1));

    // Reference model
    logic [15:0] mm [8];
    int          clr_k;
    logic [15:0] e_da [2];
    logic [15:0] e_db [2];
    logic        e_va [2];
    logic        e_vb [2];
    logic        s_va, s_vb;
    logic [15:0] s_da, s_db;
    logic        e_col, e_busy;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] merge(
        input logic [15:0] old, input logic [15:0] d, input logic [1:0] be
    );
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0] = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic idle_in();
        en_a = 0; we_a = 0; be_a = 0; addr_a = 0; din_a = 0;
        en_b = 0; we_b = 0; be_b = 0; addr_b = 0; din_b = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            e_da[i] = 0; e_db[i] = 0; e_va[i] = 0; e_vb[i] = 0;
        end
        s_va = 0; s_vb = 0; s_da = 0; s_db = 0;
        e_col = 0; e_busy = 1; clr_k = 0;
    endtask

    // Advance one clock: model reacts to current inputs, then DUT edge
    task automatic tick();
        logic busy, ac_a, ac_b, wa, wb;
        logic [15:0] oa, ob, ra1, rb1;
        busy = (clr_k >= 0);
        ac_a = en_a && !busy;
        ac_b = en_b && !busy;
        wa = ac_a && we_a;
        wb = ac_b && we_b;
        oa = mm[addr_a];
        ob = mm[addr_b];
        ra1 = wa ? merge(oa, din_a, be_a) : oa;
        rb1 = wb ? merge(ob, din_b, be_b) : ob;
        e_col = ac_a && ac_b && (addr_a == addr_b)
             && ((wa && be_a != 0) || (wb && be_b != 0));
        if (wb) mm[addr_b] = merge(mm[addr_b], din_b, be_b);
        if (wa) mm[addr_a] = merge(mm[addr_a], din_a, be_a);
        if (busy) begin
            mm[clr_k] = 16'h0;
            clr_k = (clr_k == 7) ? -1 : clr_k + 1;
        end
        e_va[0] = ac_a; if (ac_a) e_da[0] = oa;
        e_vb[0] = ac_b; if (ac_b) e_db[0] = ob;
        e_va[1] = s_va; if (s_va) e_da[1] = s_da;
        e_vb[1] = s_vb; if (s_vb) e_db[1] = s_db;
        s_va = ac_a; if (ac_a) s_da = ra1;
        s_vb = ac_b; if (ac_b) s_db = rb1;
        e_busy = (clr_k >= 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        idle_in();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({p0.dout_a, p0.valid_a, p0.dout_b, p0.valid_b,
             p0.collision, p0.init_busy} !== {16'h0, 1'b0, 16'h0, 3'b001}) begin
            errors++;
            $display("FAIL reset_dut0: got %h %b %h %b col=%b busy=%b",
                     p0.dout_a, p0.valid_a, p0.dout_b, p0.valid_b,
                     p0.collision, p0.init_busy);
        end
        checks++;
        if ({p1.dout_a, p1.valid_a, p1.dout_b, p1.valid_b,
             p1.collision, p1.init_busy} !== {16'h0, 1'b0, 16'h0, 3'b001}) begin
            errors++;
            $display("FAIL reset_dut1: got %h %b %h %b col=%b busy=%b",
                     p1.dout_a, p1.valid_a, p1.dout_b, p1.valid_b,
                     p1.collision, p1.init_busy);
        end
        rst = 0;
        en_a = 1; en_b = 1; we_a = 1; be_a = 2'b11; din_a = 16'hDEAD;
        n = 0;
        while (p0.init_busy === 1'b1 && n < 20) begin
            addr_a = 3'(n); addr_b = 3'(n);
            tick();
            n++;
            checks++;
            if ({p0.init_busy, p1.init_busy, p0.valid_a, p1.valid_b,
                 p0.collision} !== {e_busy, e_busy, 3'b000}) begin
                errors++;
                $display("FAIL clear_cycle%0d: busy=%b/%b va=%b vb=%b col=%b exp busy=%b",
                         n, p0.init_busy, p1.init_busy, p0.valid_a,
                         p1.valid_b, p0.collision, e_busy);
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL init_busy_len: got %0d clk, exp 8", n);
        end
        idle_in();
        for (int k = 0; k < 8; k++) begin
            en_a = 1; addr_a = 3'(k);
            tick();
            checks++;
            if (p0.valid_a !== 1'b1 || p0.dout_a !== 16'h0) begin
                errors++;
                $display("FAIL clear_read%0d: got %h v=%b exp 0000 v=1",
                         k, p0.dout_a, p0.valid_a);
            end
        end
        idle_in();
        tick();
        checks++;
        if (p1.valid_a !== 1'b1 || p1.dout_a !== 16'h0) begin
            errors++;
            $display("FAIL clear_read_dut1: got %h v=%b exp 0000 v=1",
                     p1.dout_a, p1.valid_a);
        end
        tick();
    endtask

    task automatic test_basic_latency();
        idle_in();
        en_a = 1; we_a = 1; addr_a = 4; din_a = 16'h000B; be_a = 2'b11;
        tick();
        checks++;
        if (p0.valid_a !== 1'b1 || p0.dout_a !== 16'h0000) begin
            errors++;
            $display("FAIL wr_cycle_read: got %h v=%b exp 0000 v=1",
                     p0.dout_a, p0.valid_a);
        end
        we_a = 0;
        tick();
        checks++;
        if (p0.valid_a !== 1'b1 || p0.dout_a !== 16'h000B) begin
            errors++;
            $display("FAIL lat1_read: got %h v=%b exp 000b v=1",
                     p0.dout_a, p0.valid_a);
        end
        checks++;
        if (p1.valid_a !== 1'b1 || p1.dout_a !== 16'h000B) begin
            errors++;
            $display("FAIL lat2_wf_wr: got %h v=%b exp 000b v=1",
                     p1.dout_a, p1.valid_a);
        end
        idle_in();
        tick();
        checks++;
        if (p1.valid_a !== 1'b1 || p1.dout_a !== 16'h000B) begin
            errors++;
            $display("FAIL lat2_read: got %h v=%b exp 000b v=1",
                     p1.dout_a, p1.valid_a);
        end
        checks++;
        if (p0.valid_a !== 1'b0 || p0.dout_a !== 16'h000B) begin
            errors++;
            $display("FAIL dout_hold: got %h v=%b exp 000b v=0",
                     p0.dout_a, p0.valid_a);
        end
        tick();
        checks++;
        if (p1.valid_a !== 1'b0 || p1.dout_a !== 16'h000B) begin
            errors++;
            $display("FAIL dout_hold_dut1: got %h v=%b exp 000b v=0",
                     p1.dout_a, p1.valid_a);
        end
    endtask

    task automatic test_byte_mask();
        idle_in();
        en_b = 1; we_b = 1; addr_b = 6; din_b = 16'h1234; be_b = 2'b11;
        tick();
        din_b = 16'hAB05; be_b = 2'b01;
        tick();
        we_b = 0; be_b = 0;
        tick();
        checks++;
        if (p0.valid_b !== 1'b1 || p0.dout_b !== 16'h1205) begin
            errors++;
            $display("FAIL byte_mask: got %h v=%b exp 1205 v=1",
                     p0.dout_b, p0.valid_b);
        end
        idle_in();
        tick();
        checks++;
        if (p1.valid_b !== 1'b1 || p1.dout_b !== 16'h1205) begin
            errors++;
            $display("FAIL byte_mask_dut1: got %h v=%b exp 1205 v=1",
                     p1.dout_b, p1.valid_b);
        end
    endtask

    task automatic test_collision();
        idle_in();
        en_a = 1; we_a = 1; addr_a = 3; din_a = 16'h0033; be_a = 2'b01;
        en_b = 1; we_b = 1; addr_b = 3; din_b = 16'hFF22; be_b = 2'b11;
        tick();
        checks++;
        if (p0.collision !== 1'b1 || p1.collision !== 1'b1) begin
            errors++;
            $display("FAIL ww_collision: got %b/%b exp 1",
                     p0.collision, p1.collision);
        end
        idle_in();
        tick();
        checks++;
        if (p0.collision !== 1'b0) begin
            errors++;
            $display("FAIL col_pulse: got %b exp 0", p0.collision);
        end
        // read/read and zero-mask write never flag or change data
        en_a = 1; we_a = 1; be_a = 2'b00; addr_a = 3; din_a = 16'hFFFF;
        en_b = 1; addr_b = 3;
        tick();
        checks++;
        if (p0.collision !== 1'b0) begin
            errors++;
            $display("FAIL be0_no_collision: got %b exp 0", p0.collision);
        end
        we_a = 0;
        tick();
        checks++;
        if (p0.collision !== 1'b0 || p0.dout_a !== 16'hFF33
            || p0.dout_b !== 16'hFF33) begin
            errors++;
            $display("FAIL rr_read: col=%b a=%h b=%h exp 0 ff33 ff33",
                     p0.collision, p0.dout_a, p0.dout_b);
        end
        idle_in();
        tick();
        checks++;
        if (p1.dout_a !== 16'hFF33 || p1.dout_b !== 16'hFF33) begin
            errors++;
            $display("FAIL ww_merge_dut1: a=%h b=%h exp ff33",
                     p1.dout_a, p1.dout_b);
        end
    endtask

    task automatic test_rdw();
        idle_in();
        en_a = 1; we_a = 1; addr_a = 1; din_a = 16'h0002; be_a = 2'b11;
        tick();
        din_a = 16'h0010;
        en_b = 1; addr_b = 1;
        tick();
        checks++;
        if (p0.dout_a !== 16'h0002 || p0.dout_b !== 16'h0002) begin
            errors++;
            $display("FAIL rdw_read_first: a=%h b=%h exp 0002 0002",
                     p0.dout_a, p0.dout_b);
        end
        checks++;
        if (p0.collision !== 1'b1 || p1.collision !== 1'b1) begin
            errors++;
            $display("FAIL rw_collision: got %b/%b exp 1",
                     p0.collision, p1.collision);
        end
        idle_in();
        tick();
        checks++;
        if (p1.dout_a !== 16'h0010 || p1.dout_b !== 16'h0002) begin
            errors++;
            $display("FAIL rdw_write_first: a=%h b=%h exp 0010 0002",
                     p1.dout_a, p1.dout_b);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en_a = 1'($urandom); we_a = 1'($urandom);
            be_a = 2'($urandom); addr_a = 3'($urandom_range(0, 3));
            din_a = 16'($urandom);
            en_b = 1'($urandom); we_b = 1'($urandom);
            be_b = 2'($urandom); addr_b = 3'($urandom_range(0, 3));
            din_b = 16'($urandom);
            tick();
            checks++;
            if ({p0.dout_a, p0.valid_a, p0.dout_b, p0.valid_b, p0.collision}
                !== {e_da[0], e_va[0], e_db[0], e_vb[0], e_col}) begin
                errors++;
                $display("FAIL rand0_%0d: got %h %b %h %b %b exp %h %b %h %b %b",
                         i, p0.dout_a, p0.valid_a, p0.dout_b, p0.valid_b,
                         p0.collision, e_da[0], e_va[0], e_db[0], e_vb[0], e_col);
            end
            checks++;
            if ({p1.dout_a, p1.valid_a, p1.dout_b, p1.valid_b, p1.collision}
                !== {e_da[1], e_va[1], e_db[1], e_vb[1], e_col}) begin
                errors++;
                $display("FAIL rand1_%0d: got %h %b %h %b %b exp %h %b %h %b %b",
                         i, p1.dout_a, p1.valid_a, p1.dout_b, p1.valid_b,
                         p1.collision, e_da[1], e_va[1], e_db[1], e_vb[1], e_col);
            end
        end
        idle_in();
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        int n;
        idle_in();
        en_a = 1; addr_a = 1;
        tick();
        idle_in();
        #2;
        rst = 1;
        model_reset();
        #1;
        checks++;
        if ({p1.dout_a, p1.valid_a, p1.init_busy, p0.dout_a, p0.valid_a}
            !== {16'h0, 2'b01, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_async: d1=%h v1=%b busy=%b d0=%h v0=%b",
                     p1.dout_a, p1.valid_a, p1.init_busy, p0.dout_a, p0.valid_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (p1.valid_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_pulse: got %b exp 0", p1.valid_a);
        end
        @(posedge clk);
        #1;
        rst = 0;
        n = 0;
        while (p1.init_busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL mid_reset_clear_len: got %0d clk, exp 8", n);
        end
        en_a = 1; addr_a = 1;
        tick();
        checks++;
        if (p0.dout_a !== 16'h0 || p0.valid_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_cleared: got %h v=%b exp 0000 v=1",
                     p0.dout_a, p0.valid_a);
        end
        idle_in();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mm[i] = 16'h0;
        test_reset();
        test_basic_latency();
        test_byte_mask();
        test_collision();
        test_rdw();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
